// File: rtl/iter_muldiv.sv
// ============================================================================
// iter_muldiv -- iterative RV32M/RV64M multiply / divide unit
//
// One request at a time.  Multiplies use radix-2 shift-add on operand
// magnitudes, and the product sign is applied at the end.  Divides use
// restoring division on magnitudes, with quotient and remainder signs
// applied at the end.  A divide by zero and the signed-overflow divide skip
// the iterations and finish after one cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   request valid (op, a, b)
//   in_ready   unit idle and able to accept a request
//   op         funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b       rs1 / rs2 operands
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts result
//   result     operation result (0 when not valid)
//   busy       FSM not idle
//   dz         divide-by-zero flag, qualified by out_valid
// ============================================================================
module iter_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            dz
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(XLEN - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;

   logic [2:0]        op_r;
   logic [XLEN-1:0]   mag_a;     // multiplicand magnitude
   logic [XLEN-1:0]   mag_b;     // divisor magnitude
   logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {rem, quo}
   logic              neg_q;     // negate product / quotient at the end
   logic              neg_r;     // negate remainder at the end
   logic              dz_pend;

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // ---- request decode -----------------------------------------------------
   logic            sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [XLEN-1:0] abs_a, abs_b;

   always_comb begin
      sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      neg_a    = sgn_a & a[XLEN-1];
      neg_b    = sgn_b & b[XLEN-1];
      abs_a    = neg_x(a, neg_a);
      abs_b    = neg_x(b, neg_b);
      div_zero = op[2] && (b == {XLEN{1'b0}});
      // only DIV/REM (op[0]==0) can overflow
      div_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == ALL_ONES);
   end

   // ---- one iteration ------------------------------------------------------
   logic [XLEN:0]     msum, rsh, rdiff;
   logic [2*XLEN-1:0] acc_next;

   always_comb begin
      msum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : {XLEN{1'b0}})};
      rsh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      rdiff = rsh - {1'b0, mag_b};
      if (!op_r[2])
         acc_next = {msum, acc[XLEN-1:1]};
      else if (!rdiff[XLEN])  // no borrow: subtract succeeds, quotient bit 1
         acc_next = {rdiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_next = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

   // ---- sign fix-up and result select --------------------------------------
   logic [2*XLEN-1:0] pfix;
   logic [XLEN-1:0]   fin;

   always_comb begin
      pfix = neg_2x(acc, neg_q);
      fin  = {XLEN{1'b0}};
      if (!op_r[2])
         fin = (op_r[1:0] == 2'b00) ? pfix[XLEN-1:0] : pfix[2*XLEN-1:XLEN];
      else if (!op_r[1])
         fin = neg_x(acc[XLEN-1:0], neg_q);
      else
         fin = neg_x(acc[2*XLEN-1:XLEN], neg_r);
   end

   // ---- datapath registers (no reset; qualified by FSM state) --------------
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         op_r  <= op;
         mag_a <= abs_a;
         mag_b <= abs_b;
         if (div_zero || div_ovf) begin
            // preload so the common fix-up yields the special-case answers
            acc     <= {(div_ovf ? {XLEN{1'b0}} : a), (div_ovf ? a : ALL_ONES)};
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_pend <= div_zero;
         end else begin
            acc     <= {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            dz_pend <= 1'b0;
         end
      end else if (state == CALC) begin
         acc <= acc_next;
      end
   end

   // ---- control FSM --------------------------------------------------------
   // DONE's first cycle applies the sign fix-up; out_valid rises on the
   // following edge and then holds until the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         dz        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt   <= '0;
                  state <= (div_zero || div_ovf) ? DONE : CALC;
               end
            end
            CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  result    <= fin;
                  dz        <= dz_pend;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  result    <= '0;
                  dz        <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule
